// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//
// Registered result/flag stage placed directly after the W-bit ripple-carry
// adder. Captures the sum, carry-out, operand sign bits and destination tag.
// Derives the NZCV flags and presents result, flags and tag to writeback over
// a valid/ready handshake.
//
// A main register plus a one-entry skid register (two entries in total) lets
// in_ready come straight from a flop. Backpressure from writeback therefore
// never forms a combinational path back into the adder.
//
// Optional feature macro: ALU_SAT_EN
//   Defined   : in_sat=1 with a signed overflow stores the saturated value.
//               N and Z follow the saturated value; C and V stay raw, so V
//               still reports the overflow.
//   Undefined : in_sat is ignored and no saturation logic is built.
//
// Parameters
//   W     datapath width (must match the adder)
//   RD_W  destination-register tag width
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    upstream holds a valid adder result
//   in_ready    stage can accept (registered)
//   in_sum      adder sum
//   in_cout     adder carry-out
//   in_a_msb    MSB of operand A as fed to the adder
//   in_b_msb    MSB of operand B as fed to the adder (post-inversion for SUB)
//   in_sat      signed saturation request
//   in_rd       destination tag
//   out_valid   result available
//   out_ready   writeback accepts
//   out_result  registered result
//   out_flags   {N,Z,C,V}
//   out_rd      registered tag
// -----------------------------------------------------------------------------
module alu_result_stage #(
  parameter int W    = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_sum,
  input  logic            in_cout,
  input  logic            in_a_msb,
  input  logic            in_b_msb,
  input  logic            in_sat,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_result,
  output logic [3:0]      out_flags,
  output logic [RD_W-1:0] out_rd
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // main invalid
    ONE   = 2'd1,  // main valid
    TWO   = 2'd2   // main and skid valid
  } state_t;

  state_t state_reg, state_next;

  logic [W-1:0]    main_result_reg, skid_result_reg;
  logic [3:0]      main_flags_reg,  skid_flags_reg;
  logic [RD_W-1:0] main_rd_reg,     skid_rd_reg;
  logic            in_ready_reg;

  // ---------------------------------------------------------------------------
  // Capture path: result and flags of the word currently on the input.
  // ---------------------------------------------------------------------------
  logic         raw_v;
  logic [W-1:0] cap_result;
  logic [3:0]   cap_flags;

  // Signed overflow: both operands share a sign that the sum does not.
  assign raw_v = (in_a_msb == in_b_msb) && (in_sum[W-1] != in_a_msb);

`ifdef ALU_SAT_EN
  always_comb begin
    cap_result = in_sum;
    if (in_sat && raw_v) begin
      // Clamp toward the sign of the operands.
      cap_result = in_a_msb ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  logic unused_sat;
  assign unused_sat = in_sat;
  assign cap_result = in_sum;
`endif

  // N and Z follow the stored value; C and V always describe the raw add.
  assign cap_flags = {cap_result[W-1], (cap_result == '0), in_cout, raw_v};

  // ---------------------------------------------------------------------------
  // Handshake and occupancy FSM
  // ---------------------------------------------------------------------------
  logic in_xfer, out_xfer;
  logic load_main, load_skid, shift_skid;

  assign out_valid = (state_reg != EMPTY);
  assign in_ready  = in_ready_reg;
  assign in_xfer   = in_valid && in_ready_reg;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    shift_skid = 1'b0;
    unique case (state_reg)
      EMPTY: begin
        if (in_xfer) begin
          load_main  = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end else if (in_xfer) begin
          load_skid  = 1'b1;
          state_next = TWO;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain side can move.
        if (out_xfer) begin
          shift_skid = 1'b1;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= EMPTY;
      in_ready_reg    <= 1'b1;
      main_result_reg <= '0;
      main_flags_reg  <= '0;
      main_rd_reg     <= '0;
      skid_result_reg <= '0;
      skid_flags_reg  <= '0;
      skid_rd_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      // Registered copy of "skid will be empty next cycle".
      in_ready_reg <= (state_next != TWO);
      if (load_main) begin
        main_result_reg <= cap_result;
        main_flags_reg  <= cap_flags;
        main_rd_reg     <= in_rd;
      end else if (shift_skid) begin
        main_result_reg <= skid_result_reg;
        main_flags_reg  <= skid_flags_reg;
        main_rd_reg     <= skid_rd_reg;
      end
      if (load_skid) begin
        skid_result_reg <= cap_result;
        skid_flags_reg  <= cap_flags;
        skid_rd_reg     <= in_rd;
      end
    end
  end

  assign out_result = main_result_reg;
  assign out_flags  = main_flags_reg;
  assign out_rd     = main_rd_reg;

endmodule
